sun_pll_lockdet: RTL



---
 rtl/sun_pll_lockdet.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/sun_pll_lockdet.sv
// PLL digital lock detector: measures REF/FB rising-edge phase error in CK cycles
// and qualifies LOCKED with separate lock/unlock tolerances and run lengths.
module sun_pll_lockdet #(
    parameter int ERR_W      = 8,
    parameter int TOL_LOCK   = 2,
    parameter int TOL_UNLOCK = 4,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             PWRUP_1V8,
    input  logic             CK_REF,
    input  logic             CK_FB,
    output logic             LOCKED,
    output logic [ERR_W-1:0] PHASE_ERR,
    output logic             PHASE_LEAD,
    output logic             ERR_VALID
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FB,
        WAIT_REF
    } state_t;

    localparam logic [ERR_W-1:0] ERR_MAX      = '1;
    localparam logic [ERR_W-1:0] TOL_LOCK_V   = ERR_W'(TOL_LOCK);
    localparam logic [ERR_W-1:0] TOL_UNLOCK_V = ERR_W'(TOL_UNLOCK);
    localparam logic [3:0]       LOCK_CNT_V   = 4'(LOCK_CNT);
    localparam logic [3:0]       UNLOCK_CNT_V = 4'(UNLOCK_CNT);

    // [0],[1] synchronizer stages, [2] history flop for edge detection
    logic [2:0]       r_ref_sync;
    logic [2:0]       r_fb_sync;
    state_t           r_state;
    logic [ERR_W-1:0] r_cnt;
    logic [3:0]       r_good;
    logic [3:0]       r_bad;
    logic             r_locked;
    logic [ERR_W-1:0] r_phase_err;
    logic             r_phase_lead;
    logic             r_err_valid;

    logic             w_ref_p;
    logic             w_fb_p;
    logic [ERR_W-1:0] w_cnt_inc;
    state_t           w_state_nxt;
    logic [ERR_W-1:0] w_cnt_nxt;
    logic             w_res_vld;
    logic [ERR_W-1:0] w_res_err;
    logic             w_res_lead;
    logic [3:0]       w_good_nxt;
    logic [3:0]       w_bad_nxt;
    logic             w_locked_nxt;

    assign w_ref_p   = r_ref_sync[1] & ~r_ref_sync[2];
    assign w_fb_p    = r_fb_sync[1] & ~r_fb_sync[2];
    assign w_cnt_inc = (r_cnt == ERR_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_res_vld   = 1'b0;
        w_res_err   = '0;
        w_res_lead  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_ref_p && w_fb_p) begin
                    w_res_vld = 1'b1;
                end else if (w_ref_p) begin
                    w_state_nxt = WAIT_FB;
                    w_cnt_nxt   = ERR_W'(1);
                end else if (w_fb_p) begin
                    w_state_nxt = WAIT_REF;
                    w_cnt_nxt   = ERR_W'(1);
                end
            end
            WAIT_FB: begin
                // a coincident REF edge both closes this measurement and opens the next
                if (w_fb_p) begin
                    w_res_vld   = 1'b1;
                    w_res_err   = r_cnt;
                    w_state_nxt = w_ref_p ? WAIT_FB : IDLE;
                    w_cnt_nxt   = w_ref_p ? ERR_W'(1) : '0;
                end else if (w_ref_p) begin
                    w_res_vld = 1'b1;
                    w_res_err = ERR_MAX;
                    w_cnt_nxt = ERR_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            WAIT_REF: begin
                w_res_lead = 1'b1;
                if (w_ref_p) begin
                    w_res_vld   = 1'b1;
                    w_res_err   = r_cnt;
                    w_state_nxt = w_fb_p ? WAIT_REF : IDLE;
                    w_cnt_nxt   = w_fb_p ? ERR_W'(1) : '0;
                end else if (w_fb_p) begin
                    w_res_vld = 1'b1;
                    w_res_err = ERR_MAX;
                    w_cnt_nxt = ERR_W'(1);
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_good_nxt   = r_good;
        w_bad_nxt    = r_bad;
        w_locked_nxt = r_locked;
        if (w_res_vld) begin
            if (!r_locked) begin
                if (w_res_err <= TOL_LOCK_V) begin
                    if (r_good + 4'd1 == LOCK_CNT_V) begin
                        w_locked_nxt = 1'b1;
                        w_good_nxt   = '0;
                    end else begin
                        w_good_nxt = r_good + 4'd1;
                    end
                end else begin
                    w_good_nxt = '0;
                end
            end else begin
                if (w_res_err > TOL_UNLOCK_V) begin
                    if (r_bad + 4'd1 == UNLOCK_CNT_V) begin
                        w_locked_nxt = 1'b0;
                        w_bad_nxt    = '0;
                    end else begin
                        w_bad_nxt = r_bad + 4'd1;
                    end
                end else begin
                    w_bad_nxt = '0;
                end
            end
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            r_ref_sync   <= '0;
            r_fb_sync    <= '0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_good       <= '0;
            r_bad        <= '0;
            r_locked     <= 1'b0;
            r_phase_err  <= '0;
            r_phase_lead <= 1'b0;
            r_err_valid  <= 1'b0;
        end else if (!PWRUP_1V8) begin
            r_ref_sync   <= '0;
            r_fb_sync    <= '0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_good       <= '0;
            r_bad        <= '0;
            r_locked     <= 1'b0;
            r_phase_err  <= '0;
            r_phase_lead <= 1'b0;
            r_err_valid  <= 1'b0;
        end else begin
            r_ref_sync  <= {r_ref_sync[1:0], CK_REF};
            r_fb_sync   <= {r_fb_sync[1:0], CK_FB};
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_good      <= w_good_nxt;
            r_bad       <= w_bad_nxt;
            r_locked    <= w_locked_nxt;
            r_err_valid <= w_res_vld;
            if (w_res_vld) begin
                r_phase_err  <= w_res_err;
                r_phase_lead <= w_res_lead;
            end
        end
    end

    assign LOCKED     = r_locked;
    assign PHASE_ERR  = r_phase_err;
    assign PHASE_LEAD = r_phase_lead;
    assign ERR_VALID  = r_err_valid;

endmodule
